// File: rtl/mul4x4_seq_ctrl.sv
// mul4x4_seq_ctrl
//
// Sequencing controller for an unsigned 4x4-bit multiply. It time-multiplexes
// an external combinational 2x2-bit multiplier over four cycles. The block
// latches the operands on an accepted start. It then walks the four 2-bit
// digit pairs (i,j) = (0,0),(0,1),(1,0),(1,1) and feeds each pair to the
// external unit. Each returned partial product is shifted by 2*(i+j) and
// added into an 8-bit accumulator. The final sum is loaded into product, and
// done pulses for one cycle.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   begin a multiplication (honoured in IDLE or DONE only)
//   a, b     in   4-bit operands, latched when start is accepted
//   busy     out  high during the four MUL cycles (registered)
//   done     out  one-cycle pulse once product is valid (registered)
//   product  out  8-bit result, held until the next operation completes
//   mul_x    out  digit of a driven to the 2x2 multiplier ({a,b} of that unit)
//   mul_y    out  digit of b driven to the 2x2 multiplier ({c,d} of that unit)
//   mul_p    in   4-bit product returned combinationally by the 2x2 multiplier

module mul4x4_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product,
    output logic [1:0] mul_x,
    output logic [1:0] mul_y,
    input  logic [3:0] mul_p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] k_reg, k_next;
    logic [3:0] a_reg, a_next;
    logic [3:0] b_reg, b_next;
    logic [7:0] acc_reg, acc_next;
    logic [7:0] product_reg, product_next;
    logic       busy_reg, done_reg;

    // Operand digits: a_dig[i] = a_reg[2i+1:2i], b_dig[j] = b_reg[2j+1:2j].
    logic [1:0] a_dig [2];
    logic [1:0] b_dig [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_digits
            assign a_dig[gi] = a_reg[2*gi +: 2];
            assign b_dig[gi] = b_reg[2*gi +: 2];
        end
    endgenerate

    // Step k encodes the digit pair directly: i = k[1], j = k[0].
    // The weight i+j is {k1&k0, k1^k0}. The shift is twice that.
    logic [2:0] shift;
    logic [7:0] partial;
    logic [7:0] sum;

    assign shift   = {k_reg[1] & k_reg[0], k_reg[1] ^ k_reg[0], 1'b0};
    assign partial = {4'b0000, mul_p} << shift;
    assign sum     = acc_reg + partial;

    always_comb begin
        state_next   = state_reg;
        k_next       = k_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        acc_next     = acc_reg;
        product_next = product_reg;
        mul_x        = 2'b00;
        mul_y        = 2'b00;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    // Accept: capture operands and clear the datapath.
                    // product keeps the previous result until this operation finishes.
                    a_next     = a;
                    b_next     = b;
                    acc_next   = 8'h00;
                    k_next     = 2'd0;
                    state_next = MUL;
                end else if (state_reg == DONE) begin
                    state_next = IDLE;
                end
            end
            MUL: begin
                mul_x    = a_dig[k_reg[1]];
                mul_y    = b_dig[k_reg[0]];
                acc_next = sum;
                // k wraps to 0 on the last step, which is harmless because
                // the next accept clears it anyway.
                k_next   = k_reg + 2'd1;
                if (k_reg == 2'd3) begin
                    // Load the completed sum, including this final partial product.
                    product_next = sum;
                    state_next   = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            k_reg       <= 2'd0;
            a_reg       <= 4'h0;
            b_reg       <= 4'h0;
            acc_reg     <= 8'h00;
            product_reg <= 8'h00;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            k_reg       <= k_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            acc_reg     <= acc_next;
            product_reg <= product_next;
            // Status flags are registered from the next state, so they track
            // the state register exactly and never glitch.
            busy_reg    <= (state_next == MUL);
            done_reg    <= (state_next == DONE);
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: doc/mul4x4_seq_ctrl.md
# mul4x4_seq_ctrl

Sequencing controller that computes an unsigned 4x4-bit product by time-multiplexing the team's combinational 2x2-bit multiplier (any of the SSI, decoder or MUX implementations) over four cycles. The block latches the operands on a start request, steps through the four 2-bit digit pairs, drives the multiplier's operand inputs, and accumulates the shifted partial products. It then reports an 8-bit result with a one-cycle done pulse. The 2x2 multiplier sits outside this block and connects through the mul_* ports.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a multiplication; sampled only in IDLE or DONE.
- a  input  4  multiplicand; latched when start is accepted.
- b  input  4  multiplier; latched when start is accepted.
- busy  output  1  high while in the MUL state.
- done  output  1  one-cycle pulse; product is valid from this cycle onward.
- product  output  8  result register; holds its value until the next accepted start.
- mul_x  output  2  operand to the 2x2 multiplier, corresponding to {a,b} of that unit.
- mul_y  output  2  operand to the 2x2 multiplier, corresponding to {c,d} of that unit.
- mul_p  input  4  2x2 product, corresponding to {f3,f2,f1,f0}; combinational and valid in the same cycle.

## Operation
- States:
  - IDLE: reset state.
  - MUL: step counter k = 0..3.
  - DONE: lasts one cycle.
- Transitions:
  - IDLE to MUL when start=1.
  - MUL stays in MUL while k<3; MUL to DONE at k=3.
  - DONE to MUL when start=1, otherwise DONE to IDLE.
- Start acceptance (IDLE or DONE with start=1):
  - a_reg <= a, b_reg <= b.
  - acc <= 0, k <= 0.
  - product is not changed at acceptance.
- Step order (i,j) = (0,0), (0,1), (1,0), (1,1) for k = 0, 1, 2, 3.
  - mul_x = a_reg[2i+1:2i].
  - mul_y = b_reg[2j+1:2j].
- Each MUL cycle: acc <= acc + ({4'b0, mul_p} << 2(i+j)).
- Width rules:
  - acc and product are 8-bit unsigned.
  - The maximum sum is 15*15 = 225, so no overflow is possible and no saturation logic is needed.
- On the MUL cycle with k=3: product <= final accumulated sum, including the k=3 partial product.
- mul_x = mul_y = 2'b00 outside MUL.
- start in MUL is ignored; there is no queueing and no error flag.
- a and b may change freely after acceptance without affecting the result.
- rst (any state, including mid-MUL) sets:
  - state IDLE, k 0, acc 0, a_reg/b_reg 0.
  - product 8'h00, busy 0, done 0.
  - The in-flight operation is discarded and no done is produced.

## Timing
- Reset values: busy=0, done=0, product=8'h00, mul_x=2'b00, mul_y=2'b00.
- Start sampled at rising edge E0:
  - MUL steps k=0..3 occupy the cycles following E0, E1, E2, E3.
  - busy=1 in those four cycles.
  - product updates at E4; done=1 in the cycle after E4.
- Latency from the start edge to done high is 5 cycles.
- Issue rate with start held or re-asserted in the DONE cycle: one result every 5 cycles.
- done and busy are never high together; both are registered outputs.
- mul_p must settle within one clk period after mul_x/mul_y change; this is a combinational path through the external multiplier.

## Test plan
- Reset then idle:
  - rst=1 for 2 cycles, then start=0 for 10 cycles.
  - Required: product=0x00, done=0, busy=0, mul_x=mul_y=0 throughout.
- Basic products, each with start=1 for one cycle:
  - a=7, b=9: product=0x3F (63).
  - a=15, b=15: product=0xE1 (225).
  - a=0, b=13: product=0x00.
  - In each case done is high exactly 5 cycles after the start edge, busy is high for exactly 4 cycles, and mul_x/mul_y step through digit pairs (3,1), (3,2), (1,1), (1,2) for a=7, b=9.
- Start while busy:
  - a=5, b=6 starts; on the second MUL cycle apply start=1 with a=15, b=15.
  - Required: product=0x1E (30), a single done, no second operation.
- Back-to-back:
  - Keep start=1 with a=3, b=3, then change to a=10, b=12 during the first DONE cycle.
  - Required: product=0x09, then 0x78 (120); dones are 5 cycles apart and there is no IDLE cycle between operations.
- Reset mid-operation:
  - Start a=15, b=15; assert rst on the third MUL cycle.
  - Required: next cycle busy=0, product=0x00, and no done pulse.
  - A following start with a=2, b=2 gives product=0x04.
- Exhaustive:
  - Run all 256 (a,b) pairs against each of the three 2x2 multiplier variants.
  - Required: product == a*b for every pair.
